conv_window_buffer: RTL and testbench
=====================================

# conv_window_buffer

Streaming sliding-window generator that feeds the convolution kernel. It accepts one multi-channel pixel per handshake in raster order and buffers FILTERHEIGHT-1 image lines. For every valid stride-1, unpadded filter position, it emits the full FILTERHEIGHT x FILTERWIDTH x DATACHANNEL window as one flattened bus. The window bus packing is identical to the kernel's `data` input, so the two connect directly.

## Interface
- BITWIDTH, 8, bits per channel sample
- DATACHANNEL, 3, channels per pixel
- FILTERHEIGHT, 5, window rows (>= 2)
- FILTERWIDTH, 5, window columns (>= 2)
- DATAWIDTH, 28, image columns (>= FILTERWIDTH)
- DATAHEIGHT, 28, image rows (>= FILTERHEIGHT)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid && in_ready
- pixel  in  BITWIDTH*DATACHANNEL  channel ch at [ch*BITWIDTH +: BITWIDTH]
- out_valid  out  1  window valid
- out_ready  in  1  window consumed when out_valid && out_ready
- window  out  BITWIDTH*DATACHANNEL*FILTERHEIGHT*FILTERWIDTH  flattened window
- out_last  out  1  qualifies the last window of a frame

## Operation
- Window packing: element i occupies [(i+1)*BITWIDTH-1 : i*BITWIDTH], with i = (r*FILTERWIDTH + c)*DATACHANNEL + ch.
  - r = 0 is the oldest (top) row.
  - c = 0 is the oldest (leftmost) column.
- Position counters col (0..DATAWIDTH-1) and row (0..DATAHEIGHT-1) track the accepted pixel.
  - col increments on every accept.
  - At col = DATAWIDTH-1, col wraps to 0 and row increments.
  - At row = DATAHEIGHT-1 with col = DATAWIDTH-1, both wrap to 0 and a new frame begins. There are no gaps between frames.
- Storage:
  - FILTERHEIGHT-1 line buffers, each DATAWIDTH pixels deep, indexed by col.
  - A FILTERHEIGHT x FILTERWIDTH pixel shift array.
- On each accept:
  - The shift array shifts left by one column.
  - The new rightmost column is line buffers (oldest to newest) plus the incoming pixel.
  - The line buffers at index col are updated as a cascade: each line takes the next newer line, and the newest line takes the pixel.
- A window is complete when the accepted pixel has row >= FILTERHEIGHT-1 and col >= FILTERWIDTH-1.
  - window is then rows row-FILTERHEIGHT+1..row and columns col-FILTERWIDTH+1..col of the current frame.
  - Stale data from a prior row or frame is never emitted.
- Windows per frame: (DATAHEIGHT-FILTERHEIGHT+1)*(DATAWIDTH-FILTERWIDTH+1).
- out_last = 1 only with the window completed by pixel (DATAHEIGHT-1, DATAWIDTH-1).
- Output is a one-entry register. in_ready = !rst && (!out_valid || out_ready).
  - A pixel that completes a window is accepted only when the output register is free or being drained that cycle.
  - Non-completing pixels obey the same in_ready rule. in_ready is never data-dependent.

## Timing
- Reset (rst high at a clock edge):
  - out_valid = 0, out_last = 0, window = 0.
  - col = 0, row = 0.
  - Shift array and line buffers need not be cleared.
- in_ready = 0 while rst is high; in_ready = 1 on the first cycle after reset.
- Latency: the window completed by a pixel accepted at edge N is visible with out_valid = 1 after edge N (the next cycle).
- window and out_last are held stable while out_valid && !out_ready.
- Simultaneous drain and new completing accept: window and out_last load the new values and out_valid stays 1. Full throughput is one window per cycle.
- Drain with no new completing accept: out_valid goes 0 after that edge.
- Reset mid-frame: the partial frame is discarded and any pending window is dropped. The first pixel after reset is (0,0) of a new frame.
- in_valid low: no state change except output drain.

## Test plan
- Config BITWIDTH=8, DATACHANNEL=1, 3x3 filter, 5x5 image; pixel = row*5+col streamed with out_ready=1.
  - The first out_valid occurs one cycle after pixel 12 is accepted.
  - window elements 0..8 = 0,1,2,5,6,7,10,11,12.
- Same config, full frame: exactly 9 windows, in order.
  - The last window is 12,13,14,17,18,19,22,23,24 with out_last = 1.
  - out_last = 0 on all others.
- Back-to-back frames with no idle cycles: the second frame's first window is again 0,1,2,5,6,7,10,11,12 (values re-streamed). No window is emitted for row < 2 of frame 2.
- Backpressure: hold out_ready = 0 after the first window.
  - in_ready drops to 0 and window holds 0,1,2,5,6,7,10,11,12.
  - Releasing out_ready resumes the stream with no lost or duplicated windows.
- Reset asserted after pixel 17 for one cycle, then the stream restarts.
  - out_valid = 0 and in_ready = 0 during reset.
  - The first window after restart is 0,1,2,5,6,7,10,11,12.
- DATACHANNEL=2, ch0 = row*5+col, ch1 = 100+row*5+col.
  - The first window's elements 0..3 = 0,100,1,101.
  - Element 17 = 112.

Source files
------------

// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out handshake bundle for the sliding-window generator.
// Widths are derived from the same parameters as the design instance.
interface conv_window_buffer_if #(
    parameter int BITWIDTH     = 8,
    parameter int DATACHANNEL  = 3,
    parameter int FILTERHEIGHT = 5,
    parameter int FILTERWIDTH  = 5
);
    localparam int PW = BITWIDTH * DATACHANNEL;
    localparam int WW = PW * FILTERHEIGHT * FILTERWIDTH;

    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] pixel;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] window;
    logic          out_last;

    modport master (
        output in_valid,
        output pixel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  window,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  pixel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output window,
        output out_last
    );
endinterface

// File: rtl/conv_window_buffer.sv
// Streaming stride-1 sliding-window generator: line buffers plus a tap array,
// emitting one flattened FILTERHEIGHT x FILTERWIDTH x DATACHANNEL window per position.
module conv_window_buffer #(
    parameter int BITWIDTH     = 8,
    parameter int DATACHANNEL  = 3,
    parameter int FILTERHEIGHT = 5,
    parameter int FILTERWIDTH  = 5,
    parameter int DATAWIDTH    = 28,
    parameter int DATAHEIGHT   = 28
) (
    input  logic clk,
    input  logic rst,
    conv_window_buffer_if.slave bus
);
    localparam int PW = BITWIDTH * DATACHANNEL;
    localparam int WW = PW * FILTERHEIGHT * FILTERWIDTH;
    localparam int NL = FILTERHEIGHT - 1;
    localparam int CW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
    localparam int RW = (DATAHEIGHT > 1) ? $clog2(DATAHEIGHT) : 1;

    logic [PW-1:0] lines     [NL][DATAWIDTH];
    logic [PW-1:0] taps      [FILTERHEIGHT][FILTERWIDTH];
    logic [PW-1:0] taps_next [FILTERHEIGHT][FILTERWIDTH];
    logic [PW-1:0] column    [FILTERHEIGHT];

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_end;
    logic          row_end;
    logic          complete;
    logic          accept;
    logic          ready;

    logic          valid_q;
    logic          last_q;
    logic [WW-1:0] window_q;
    logic [WW-1:0] window_next;

    assign ready    = !rst && (!valid_q || bus.out_ready);
    assign accept   = bus.in_valid && ready;
    assign col_end  = (col == CW'(DATAWIDTH - 1));
    assign row_end  = (row == RW'(DATAHEIGHT - 1));
    assign complete = (row >= RW'(FILTERHEIGHT - 1)) &&
                      (col >= CW'(FILTERWIDTH - 1));

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.window    = window_q;

    // Incoming rightmost column: buffered lines oldest-first, then the live pixel.
    always_comb begin
        for (int r = 0; r < FILTERHEIGHT; r++) begin
            column[r] = '0;
        end
        for (int r = 0; r < NL; r++) begin
            column[r] = lines[r][col];
        end
        column[NL] = bus.pixel;
    end

    always_comb begin
        for (int r = 0; r < FILTERHEIGHT; r++) begin
            for (int c = 0; c < FILTERWIDTH - 1; c++) begin
                taps_next[r][c] = taps[r][c+1];
            end
            taps_next[r][FILTERWIDTH-1] = column[r];
        end
    end

    always_comb begin
        window_next = '0;
        for (int r = 0; r < FILTERHEIGHT; r++) begin
            for (int c = 0; c < FILTERWIDTH; c++) begin
                window_next[(r*FILTERWIDTH + c)*PW +: PW] = taps_next[r][c];
            end
        end
    end

    // Pixel storage carries no reset; counters guarantee stale data is never used.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < NL - 1; r++) begin
                lines[r][col] <= lines[r+1][col];
            end
            lines[NL-1][col] <= bus.pixel;
            taps <= taps_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            window_q <= '0;
        end else if (accept && complete) begin
            valid_q  <= 1'b1;
            last_q   <= row_end && col_end;
            window_q <= window_next;
        end else if (bus.out_ready) begin
            valid_q  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench: 3x3 window over a 5x5 image, one and two channels.
// Expected windows are computed from pixel coordinates when each pixel is accepted.
module tb_conv_window_buffer;
    localparam int WA = 8 * 1 * 9;
    localparam int WB = 8 * 2 * 9;

    logic clk;
    logic rst;

    conv_window_buffer_if #(.BITWIDTH(8), .DATACHANNEL(1),
        .FILTERHEIGHT(3), .FILTERWIDTH(3)) bus_a ();
    conv_window_buffer_if #(.BITWIDTH(8), .DATACHANNEL(2),
        .FILTERHEIGHT(3), .FILTERWIDTH(3)) bus_b ();

    conv_window_buffer #(
        .BITWIDTH(8), .DATACHANNEL(1), .FILTERHEIGHT(3),
        .FILTERWIDTH(3), .DATAWIDTH(5), .DATAHEIGHT(5)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    conv_window_buffer #(
        .BITWIDTH(8), .DATACHANNEL(2), .FILTERHEIGHT(3),
        .FILTERWIDTH(3), .DATAWIDTH(5), .DATAHEIGHT(5)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int wins_a   = 0;
    int wins_b   = 0;

    logic [WA-1:0] qa_win [$];
    bit            qa_last [$];
    logic [WB-1:0] qb_win [$];
    bit            qb_last [$];

    logic [WA-1:0] ew_a;
    bit            el_a;
    logic [WB-1:0] ew_b;
    bit            el_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WA-1:0] exp_a(int r, int c);
        logic [WA-1:0] w;
        w = '0;
        for (int ri = 0; ri < 3; ri++)
            for (int ci = 0; ci < 3; ci++)
                w[(ri*3 + ci)*8 +: 8] = 8'((r - 2 + ri)*5 + c - 2 + ci);
        return w;
    endfunction

    function automatic logic [WB-1:0] exp_b(int r, int c);
        logic [WB-1:0] w;
        w = '0;
        for (int ri = 0; ri < 3; ri++)
            for (int ci = 0; ci < 3; ci++)
                for (int ch = 0; ch < 2; ch++)
                    w[((ri*3 + ci)*2 + ch)*8 +: 8] =
                        8'(ch*100 + (r - 2 + ri)*5 + c - 2 + ci);
        return w;
    endfunction

    // Consumption happens at the next rising edge; inputs settle at the falling edge.
    always @(negedge clk) begin
        #2;
        if (!rst && bus_a.out_valid && bus_a.out_ready) begin
            n_checks++;
            wins_a++;
            if (qa_win.size() == 0) begin
                $display("FAIL win_a_unexpected got=%h expected=none",
                         bus_a.window);
            end else begin
                ew_a = qa_win.pop_front();
                el_a = qa_last.pop_front();
                if (bus_a.window !== ew_a || bus_a.out_last !== el_a)
                    $display("FAIL win_a got=%h last=%b expected=%h last=%b",
                             bus_a.window, bus_a.out_last, ew_a, el_a);
                else
                    n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst && bus_b.out_valid && bus_b.out_ready) begin
            n_checks++;
            wins_b++;
            if (qb_win.size() == 0) begin
                $display("FAIL win_b_unexpected got=%h expected=none",
                         bus_b.window);
            end else begin
                ew_b = qb_win.pop_front();
                el_b = qb_last.pop_front();
                if (bus_b.window !== ew_b || bus_b.out_last !== el_b)
                    $display("FAIL win_b got=%h last=%b expected=%h last=%b",
                             bus_b.window, bus_b.out_last, ew_b, el_b);
                else
                    n_pass++;
            end
        end
    end

    task automatic send_a(input int r, input int c);
        int t;
        t = 0;
        @(negedge clk);
        bus_a.in_valid = 1'b1;
        bus_a.pixel    = 8'(r*5 + c);
        #1;
        while (!bus_a.in_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus_a.in_ready) begin
            n_checks++;
            $display("FAIL send_a_timeout r=%0d c=%0d in_ready=%b expected=1",
                     r, c, bus_a.in_ready);
        end else begin
            if (r >= 2 && c >= 2) begin
                qa_win.push_back(exp_a(r, c));
                qa_last.push_back(r == 4 && c == 4);
            end
            @(posedge clk);
        end
    endtask

    task automatic send_b(input int r, input int c);
        int t;
        t = 0;
        @(negedge clk);
        bus_b.in_valid = 1'b1;
        bus_b.pixel    = {8'(100 + r*5 + c), 8'(r*5 + c)};
        #1;
        while (!bus_b.in_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!bus_b.in_ready) begin
            n_checks++;
            $display("FAIL send_b_timeout r=%0d c=%0d in_ready=%b expected=1",
                     r, c, bus_b.in_ready);
        end else begin
            if (r >= 2 && c >= 2) begin
                qb_win.push_back(exp_b(r, c));
                qb_last.push_back(r == 4 && c == 4);
            end
            @(posedge clk);
        end
    endtask

    // Streams one frame, checking out_valid timing after every accept.
    task automatic stream_frame_a();
        bit exp_v;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                send_a(r, c);
                #1;
                exp_v = (r >= 2 && c >= 2);
                n_checks++;
                if (bus_a.out_valid !== exp_v)
                    $display("FAIL valid_timing r=%0d c=%0d got=%b expected=%b",
                             r, c, bus_a.out_valid, exp_v);
                else
                    n_pass++;
            end
        end
    endtask

    task automatic idle_a(input int n);
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_count_a(input int expected, input string name);
        n_checks++;
        if (wins_a !== expected || qa_win.size() != 0)
            $display("FAIL %s windows=%0d pending=%0d expected=%0d pending=0",
                     name, wins_a, qa_win.size(), expected);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.out_last !== 1'b0 ||
            bus_a.window !== '0 || bus_a.in_ready !== 1'b0)
            $display("FAIL reset_state v=%b l=%b w=%h rdy=%b expected 0,0,0,0",
                     bus_a.out_valid, bus_a.out_last, bus_a.window,
                     bus_a.in_ready);
        else
            n_pass++;
        n_checks++;
        if (bus_b.out_valid !== 1'b0 || bus_b.window !== '0)
            $display("FAIL reset_state_b v=%b w=%h expected 0,0",
                     bus_b.out_valid, bus_b.window);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus_a.in_ready !== 1'b1)
            $display("FAIL ready_after_reset got=%b expected=1", bus_a.in_ready);
        else
            n_pass++;
    endtask

    task automatic test_first_frame();
        int first_vals[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int last_vals[9]  = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
        logic [WA-1:0] w;
        wins_a = 0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                send_a(r, c);
                #1;
                w = bus_a.window;
                if (r == 2 && c == 2) begin
                    for (int i = 0; i < 9; i++) begin
                        n_checks++;
                        if (w[i*8 +: 8] !== 8'(first_vals[i]))
                            $display("FAIL first_win elem=%0d got=%0d expected=%0d",
                                     i, w[i*8 +: 8], first_vals[i]);
                        else
                            n_pass++;
                    end
                end
                if (r == 4 && c == 4) begin
                    n_checks++;
                    if (bus_a.out_last !== 1'b1)
                        $display("FAIL last_flag got=%b expected=1", bus_a.out_last);
                    else
                        n_pass++;
                    for (int i = 0; i < 9; i++) begin
                        n_checks++;
                        if (w[i*8 +: 8] !== 8'(last_vals[i]))
                            $display("FAIL last_win elem=%0d got=%0d expected=%0d",
                                     i, w[i*8 +: 8], last_vals[i]);
                        else
                            n_pass++;
                    end
                end
                if (r == 4 && c == 3) begin
                    n_checks++;
                    if (bus_a.out_last !== 1'b0)
                        $display("FAIL early_last got=%b expected=0", bus_a.out_last);
                    else
                        n_pass++;
                end
            end
        end
        idle_a(3);
        check_count_a(9, "frame_count");
        n_checks++;
        if (bus_a.out_valid !== 1'b0)
            $display("FAIL drained got=%b expected=0", bus_a.out_valid);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        wins_a = 0;
        stream_frame_a();
        stream_frame_a();
        idle_a(3);
        check_count_a(18, "b2b_count");
    endtask

    task automatic test_backpressure();
        wins_a = 0;
        fork
            stream_frame_a();
            begin
                int t;
                t = 0;
                while (!bus_a.out_valid && t < 60) begin
                    @(negedge clk);
                    t++;
                end
                if (!bus_a.out_valid) begin
                    n_checks++;
                    $display("FAIL bp_wait out_valid=%b expected=1",
                             bus_a.out_valid);
                end else begin
                    bus_a.out_ready = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        #1;
                        n_checks++;
                        if (bus_a.in_ready !== 1'b0 || bus_a.out_valid !== 1'b1 ||
                            bus_a.window !== exp_a(2, 2))
                            $display("FAIL bp_hold rdy=%b v=%b w=%h expected 0,1,%h",
                                     bus_a.in_ready, bus_a.out_valid,
                                     bus_a.window, exp_a(2, 2));
                        else
                            n_pass++;
                    end
                    @(negedge clk);
                    bus_a.out_ready = 1'b1;
                end
            end
        join
        idle_a(3);
        check_count_a(9, "bp_count");
    endtask

    task automatic test_reset_midframe();
        wins_a = 0;
        for (int i = 0; i <= 17; i++) send_a(i / 5, i % 5);
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        rst = 1'b1;
        qa_win.delete();
        qa_last.delete();
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b0)
            $display("FAIL mid_reset v=%b rdy=%b expected 0,0",
                     bus_a.out_valid, bus_a.in_ready);
        else
            n_pass++;
        n_checks++;
        if (wins_a !== 3)
            $display("FAIL pre_reset_count got=%0d expected=3", wins_a);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b0;
        wins_a = 0;
        stream_frame_a();
        idle_a(3);
        check_count_a(9, "restart_count");
    endtask

    task automatic test_two_channel();
        int head[4] = '{0, 100, 1, 101};
        logic [WB-1:0] w;
        wins_b = 0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                send_b(r, c);
                #1;
                if (r == 2 && c == 2) begin
                    w = bus_b.window;
                    for (int i = 0; i < 4; i++) begin
                        n_checks++;
                        if (w[i*8 +: 8] !== 8'(head[i]))
                            $display("FAIL ch2_elem elem=%0d got=%0d expected=%0d",
                                     i, w[i*8 +: 8], head[i]);
                        else
                            n_pass++;
                    end
                    n_checks++;
                    if (w[17*8 +: 8] !== 8'd112)
                        $display("FAIL ch2_elem17 got=%0d expected=112",
                                 w[17*8 +: 8]);
                    else
                        n_pass++;
                end
            end
        end
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wins_b !== 9 || qb_win.size() != 0)
            $display("FAIL ch2_count windows=%0d pending=%0d expected=9 pending=0",
                     wins_b, qb_win.size());
        else
            n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t expected completion", $time);
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus_a.in_valid  = 1'b0;
        bus_a.pixel     = '0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.pixel     = '0;
        bus_b.out_ready = 1'b1;
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_two_channel();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
